// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key sequencer: prefix bytes,
// FSM state encodings and the key event record carried through the FIFO.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  typedef enum logic [1:0] {PFX_BASE, PFX_EXT, PFX_BRK, PFX_EXTBRK} pfx_state_e;
  typedef enum logic [1:0] {RX_RESYNC, RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and deglitches the pins, shifts in
// 11-bit frames and flags parity/stop/timeout errors.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbdclk_i,
  input  logic       kbddat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_flt_q, clk_flt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  rx_state_e     state_q, state_d;
  logic          fall, dat_s;

  assign dat_s = dat_sync_q[1];

  // The filtered clock only moves after FILTER_LEN samples that disagree with it.
  always_comb begin
    fall      = 1'b0;
    flt_cnt_d = '0;
    clk_flt_d = clk_flt_q;
    if (clk_sync_q[1] != clk_flt_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        clk_flt_d = clk_sync_q[1];
        fall      = clk_flt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      RX_RESYNC: begin
        if (!clk_flt_q) tcnt_d = '0;
        else if (tcnt_q == TO_LAST) begin
          tcnt_d  = '0;
          state_d = RX_IDLE;
        end else tcnt_d = tcnt_q + TW'(1);
      end
      RX_IDLE: begin
        tcnt_d   = '0;
        bitcnt_d = '0;
        if (fall && !dat_s) state_d = RX_SHIFT;
      end
      RX_SHIFT: begin
        // shreg ends as {stop, parity, d7..d0}
        if (fall) begin
          tcnt_d   = '0;
          shreg_d  = {dat_s, shreg_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = RX_CHECK;
        end else if (tcnt_q == TO_LAST) begin
          tcnt_d      = '0;
          frame_err_d = 1'b1;
          state_d     = RX_RESYNC;
        end else tcnt_d = tcnt_q + TW'(1);
      end
      RX_CHECK: begin
        tcnt_d = '0;
        if ((^shreg_q[8:0]) && shreg_q[9]) begin
          byte_valid_d = 1'b1;
          state_d      = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RX_RESYNC;
        end
      end
      default: state_d = RX_RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_flt_q    <= 1'b1;
      flt_cnt_q    <= '0;
      tcnt_q       <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= RX_RESYNC;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], kbdclk_i};
      dat_sync_q   <= {dat_sync_q[0], kbddat_i};
      clk_flt_q    <= clk_flt_d;
      flt_cnt_q    <= flt_cnt_d;
      tcnt_q       <= tcnt_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
    end
  end

  // shreg is untouched in IDLE, so the byte stays valid alongside the strobe.
  assign byte_o       = shreg_q[7:0];
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q == RX_SHIFT) || (state_q == RX_CHECK);
endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 key sequencer: folds E0/F0 prefixes into key events and queues them
// for a valid/ready consumer.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .kbdclk_i     (kbdclk),
    .kbddat_i     (kbddat),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  pfx_state_e pfx_q, pfx_d;
  key_event_t ev_in, head;
  logic       push, pop, full, accept;

  always_comb begin
    pfx_d      = pfx_q;
    push       = 1'b0;
    ev_in.ext  = (pfx_q == PFX_EXT) || (pfx_q == PFX_EXTBRK);
    ev_in.brk  = (pfx_q == PFX_BRK) || (pfx_q == PFX_EXTBRK);
    ev_in.code = rx_byte;
    if (frame_err) pfx_d = PFX_BASE;
    else if (rx_valid) begin
      if (rx_byte == PS2_EXT)
        pfx_d = (pfx_q == PFX_BASE || pfx_q == PFX_EXT) ? PFX_EXT : PFX_EXTBRK;
      else if (rx_byte == PS2_BRK)
        pfx_d = (pfx_q == PFX_BASE || pfx_q == PFX_BRK) ? PFX_BRK : PFX_EXTBRK;
      else begin
        // 00/FF are keyboard error codes; only meaningful as standalone bytes
        push  = !(pfx_q == PFX_BASE && (rx_byte == PS2_ERR0 || rx_byte == PS2_ERR1));
        pfx_d = PFX_BASE;
      end
    end
  end

  key_event_t      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     cnt_q;

  assign ev_valid = (cnt_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign full     = (cnt_q == FULL_CNT);
  assign accept   = push && (!full || pop);
  assign head     = mem[rd_q];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= ev_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pfx_q    <= PFX_BASE;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      pfx_q <= pfx_d;
      if (accept) wr_q <= wr_q + AW'(1);
      if (pop)    rd_q <= rd_q + AW'(1);
      case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign ev_code  = ev_valid ? head.code : 8'h00;
  assign ev_break = ev_valid && head.brk;
  assign ev_ext   = ev_valid && head.ext;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: table of byte sequences plus
// hand-written latency, error, timeout, reset and overflow sequences.
module tb_ps2_key_sequencer;
  localparam int FL   = 2;
  localparam int TO   = 64;
  localparam int HALF = 20;  // kbdclk low time; full bit period is 2*HALF = 40 clk

  logic       clk = 1'b0, reset = 1'b1, kbdclk = 1'b1, kbddat = 1'b1, ev_ready = 1'b1;
  logic       ev_valid, ev_break, ev_ext, frame_err, overflow, busy;
  logic [7:0] ev_code;

  ps2_key_sequencer #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .kbdclk(kbdclk), .kbddat(kbddat),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext), .frame_err(frame_err),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, err_cnt = 0, lat = 0, e0 = 0;
  logic [9:0] evq[$];  // accepted events as {ext, brk, code}

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_break, ev_code});
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // lat records the first clk after the falling edge at which ev_valid is seen
  task automatic send_bit(input logic b, input bit measure);
    kbddat = b;
    repeat (HALF / 2) @(posedge clk);
    #1 kbdclk = 1'b0;
    lat = 0;
    for (int i = 1; i <= HALF; i++) begin
      @(posedge clk);
      #1;
      if (measure && lat == 0 && ev_valid) lat = i;
    end
    kbdclk = 1'b1;
    repeat (HALF / 2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit measure);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, measure);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i], 1'b0);
  endtask

  typedef struct {
    logic [2:0][7:0] b;    // b[0] is sent first
    int              nb;
    int              nev;
    logic [9:0]      exp;  // {ext, brk, code}
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{b: 24'h00001C, nb: 1, nev: 1, exp: 10'h01C};
    vecs[1] = '{b: 24'h002BF0, nb: 2, nev: 1, exp: 10'h12B};
    vecs[2] = '{b: 24'h75F0E0, nb: 3, nev: 1, exp: 10'h375};
    vecs[3] = '{b: 24'h000075, nb: 1, nev: 1, exp: 10'h075};
    vecs[4] = '{b: 24'h1FE0E0, nb: 3, nev: 1, exp: 10'h21F};
    vecs[5] = '{b: 24'h000000, nb: 1, nev: 0, exp: 10'h000};
    vecs[6] = '{b: 24'h0000E1, nb: 1, nev: 1, exp: 10'h0E1};
    vecs[7] = '{b: 24'h70E0F0, nb: 3, nev: 1, exp: 10'h370};

    wait_clks(5);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_brk_ext", {ev_break, ev_ext}, 0);
    chk("rst_err_ovf_busy", {frame_err, overflow, busy}, 0);
    reset = 1'b0;
    wait_clks(100);

    // Stop-bit fall is seen 2 sync + 2 filter cycles after the pin drops,
    // then 3 more cycles to ev_valid.
    evq.delete();
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("latency", lat, 6);
    wait_clks(10);
    chk("first_n", evq.size(), 1);
    if (evq.size() > 0) chk("first_ev", evq[0], 10'h01C);

    for (int k = 0; k < 8; k++) begin
      evq.delete();
      for (int j = 0; j < vecs[k].nb; j++) send_frame(vecs[k].b[j], 1'b0, 1'b0);
      wait_clks(10);
      chk($sformatf("vec%0d_n", k), evq.size(), vecs[k].nev);
      if (vecs[k].nev > 0 && evq.size() > 0) chk($sformatf("vec%0d_ev", k), evq[0], vecs[k].exp);
    end

    // parity error then recovery
    evq.delete();
    e0 = err_cnt;
    send_frame(8'h2B, 1'b1, 1'b0);
    wait_clks(10);
    chk("par_err", err_cnt, e0 + 1);
    chk("par_noev", evq.size(), 0);
    wait_clks(100);
    send_frame(8'h2B, 1'b0, 1'b0);
    wait_clks(10);
    chk("par_rec_n", evq.size(), 1);
    if (evq.size() > 0) chk("par_rec_ev", evq[0], 10'h02B);

    // timeout mid-frame
    evq.delete();
    e0 = err_cnt;
    send_partial(8'h1C, 5);
    chk("to_busy1", busy, 1);
    wait_clks(100);
    chk("to_err", err_cnt, e0 + 1);
    chk("to_busy0", busy, 0);
    wait_clks(100);

    // reset mid-frame
    send_partial(8'h1C, 3);
    chk("rst_mid_busy", busy, 1);
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(100);
    chk("rst_mid_err", err_cnt, e0 + 1);
    chk("rst_mid_noev", evq.size(), 0);
    chk("rst_mid_busy0", busy, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_clks(10);
    chk("rst_rec_n", evq.size(), 1);
    if (evq.size() > 0) chk("rst_rec_ev", evq[0], 10'h01C);

    // overflow
    evq.delete();
    ev_ready = 1'b0;
    send_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    send_frame(8'h2D, 1'b0, 1'b0);
    wait_clks(10);
    chk("ovf_before", overflow, 0);
    chk("ovf_head", {ev_valid, ev_code}, 9'h115);
    send_frame(8'h2C, 1'b0, 1'b0);
    wait_clks(10);
    chk("ovf_set", overflow, 1);
    chk("ovf_hold", {ev_valid, ev_code}, 9'h115);
    ev_ready = 1'b1;
    wait_clks(10);
    chk("ovf_n", evq.size(), 4);
    if (evq.size() == 4) begin
      chk("ovf_ev0", evq[0], 10'h015);
      chk("ovf_ev1", evq[1], 10'h01D);
      chk("ovf_ev2", evq[2], 10'h024);
      chk("ovf_ev3", evq[3], 10'h02D);
    end
    chk("ovf_empty", ev_valid, 0);
    chk("ovf_sticky", overflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
